serial_addsub: RTL and testbench

- Multi-cycle, digit-serial adder/subtractor. It is the add-side counterpart of the team's DW01-style combinational subtractor macros.
- Processes WIDTH-bit operands DIGIT bits per clock, LSB first, with a ripple carry held in a register between cycles.
- Intended for area-constrained datapaths where a full-width carry chain is not wanted.
- Valid/ready handshake on both input and output. One operation in flight at a time.

---
 rtl/serial_addsub_if.sv | 27 ++
 rtl/serial_addsub.sv | 96 +++++++++
 tb/tb_serial_addsub.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
// The master side supplies operands and accepts results; the slave side is the arithmetic block.
interface serial_addsub_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic             op_sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             co;
   logic             ovf;

   modport master (
      output in_valid, op_sub, a, b, ci, out_ready,
      input  in_ready, out_valid, result, co, ovf
   );

   modport slave (
      input  in_valid, op_sub, a, b, ci, out_ready,
      output in_ready, out_valid, result, co, ovf
   );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, ripple carry held in a register.
// Subtraction is a + ~b + ~ci; the final carry is inverted to give the borrow.
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input logic            clk,
   input logic            rst_n,
   serial_addsub_if.slave bus
);
   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_addsub: DIGIT must divide WIDTH exactly");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
   logic             carry_q, sub_q, co_q, ovf_q;
   logic [CNT_W-1:0] cnt_q;

   logic             accept, last;
   logic [DIGIT-1:0] a_dig, b_dig, sum_dig;
   logic             c_out, c_msb;
   logic [WIDTH-1:0] acc_next;

   assign accept = (state_q == IDLE) && bus.in_valid;
   assign last   = (cnt_q == CNT_W'(N - 1));

   // Operands shift right each cycle so the active digit always sits at the bottom;
   // sum digits enter the accumulator from the top and land in place after N cycles.
   always_comb begin
      a_dig              = a_q[DIGIT-1:0];
      b_dig              = b_q[DIGIT-1:0];
      {c_out, sum_dig}   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
      c_msb              = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ sum_dig[DIGIT-1];
      acc_next           = (acc_q >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid)  state_d = RUN;
         RUN:     if (last)          state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Published result/co/ovf only change on the last digit, so they hold through DONE and IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         sub_q    <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         co_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (accept) begin
         a_q     <= bus.a;
         b_q     <= bus.op_sub ? ~bus.b : bus.b;
         carry_q <= bus.ci ^ bus.op_sub;
         sub_q   <= bus.op_sub;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else if (state_q == RUN) begin
         a_q     <= a_q >> DIGIT;
         b_q     <= b_q >> DIGIT;
         carry_q <= c_out;
         acc_q   <= acc_next;
         cnt_q   <= cnt_q + 1'b1;
         if (last) begin
            result_q <= acc_next;
            co_q     <= c_out ^ sub_q;
            ovf_q    <= c_msb ^ c_out;
         end
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.co        = co_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: DIGIT = 4, 1 and 8 instances share one stimulus stream;
// a per-instance scoreboard checks results and latency, directed steps check handshake timing.
module tb_serial_addsub;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, op_sub, ci, out_ready;
   logic [7:0] a, b;

   int n_cmp = 0;
   int n_err = 0;
   int n_ops = 0;
   int outs [3];
   int lat  [3];
   int nlat [3] = '{2, 8, 1};
   bit busy [3];
   bit lchk [3];

   logic [9:0] q0[$], q1[$], q2[$];

   serial_addsub_if #(.WIDTH(8)) if4 ();
   serial_addsub_if #(.WIDTH(8)) if1 ();
   serial_addsub_if #(.WIDTH(8)) if8 ();

   serial_addsub #(.WIDTH(8), .DIGIT(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
   serial_addsub #(.WIDTH(8), .DIGIT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   serial_addsub #(.WIDTH(8), .DIGIT(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

   assign if4.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if8.in_valid = in_valid;
   assign if4.op_sub = op_sub;      assign if1.op_sub = op_sub;      assign if8.op_sub = op_sub;
   assign if4.a = a;                assign if1.a = a;                assign if8.a = a;
   assign if4.b = b;                assign if1.b = b;                assign if8.b = b;
   assign if4.ci = ci;              assign if1.ci = ci;              assign if8.ci = ci;
   assign if4.out_ready = out_ready; assign if1.out_ready = out_ready; assign if8.out_ready = out_ready;

   logic       ov [3];
   logic       ir [3];
   logic [9:0] obs [3];
   assign ov[0] = if4.out_valid; assign ov[1] = if1.out_valid; assign ov[2] = if8.out_valid;
   assign ir[0] = if4.in_ready;  assign ir[1] = if1.in_ready;  assign ir[2] = if8.in_ready;
   assign obs[0] = {if4.ovf, if4.co, if4.result};
   assign obs[1] = {if1.ovf, if1.co, if1.result};
   assign obs[2] = {if8.ovf, if8.co, if8.result};

   always #5 clk = ~clk;

   // Reference: {ovf, co, result}
   function automatic logic [9:0] ref_calc(logic op, logic [7:0] x, logic [7:0] y, logic c);
      logic [8:0] u;
      int         sv;
      logic       brw;
      if (!op) begin
         u   = {1'b0, x} + {1'b0, y} + {8'd0, c};
         sv  = int'($signed(x)) + int'($signed(y)) + int'(c);
         brw = u[8];
      end else begin
         u   = {1'b0, x} - {1'b0, y} - {8'd0, c};
         sv  = int'($signed(x)) - int'($signed(y)) - int'(c);
         brw = ({1'b0, x} < ({1'b0, y} + {8'd0, c}));
      end
      return {((sv > 127) || (sv < -128)), brw, u[7:0]};
   endfunction

   task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int qsize(int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic push_exp(int k, logic [9:0] v);
      case (k)
         0:       q0.push_back(v);
         1:       q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   task automatic pop_exp(int k, output logic [9:0] v);
      case (k)
         0:       v = q0.pop_front();
         1:       v = q1.pop_front();
         default: v = q2.pop_front();
      endcase
   endtask

   // Scoreboard: sampled on the falling edge, reflecting what the next rising edge will transfer
   always @(negedge clk) begin
      logic [9:0] e;
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            busy[k] = 1'b0;
            case (k)
               0:       q0.delete();
               1:       q1.delete();
               default: q2.delete();
            endcase
         end else begin
            if (busy[k]) begin
               lat[k]++;
               if (ov[k] && !lchk[k]) begin
                  lchk[k] = 1'b1;
                  chk($sformatf("latency_i%0d", k), lat[k], nlat[k]);
               end
            end
            if (ov[k] && out_ready) begin
               chk($sformatf("sb_depth_i%0d", k), qsize(k), 1);
               if (qsize(k) > 0) begin
                  pop_exp(k, e);
                  chk($sformatf("sb_result_i%0d", k), obs[k], e);
               end
               busy[k] = 1'b0;
               outs[k]++;
            end
            if (in_valid && ir[k]) begin
               push_exp(k, ref_calc(op_sub, a, b, ci));
               busy[k] = 1'b1;
               lat[k]  = -1;
               lchk[k] = 1'b0;
            end
         end
      end
   end

   task automatic wait_idle();
      int k = 0;
      while (!(ir[0] && ir[1] && ir[2]) && k < 100) begin
         tick();
         k++;
      end
      chk("idle_wait", {31'd0, ir[0] && ir[1] && ir[2]}, 1);
   endtask

   task automatic issue(logic op, logic [7:0] x, logic [7:0] y, logic c);
      op_sub = op; a = x; b = y; ci = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_ops++;
      wait_idle();
   endtask

   task automatic chk_all(string tag, logic [9:0] e);
      for (int k = 0; k < 3; k++) chk($sformatf("%s_i%0d", tag, k), obs[k], e);
   endtask

   initial begin
      int k;
      rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; ci = 1'b0; out_ready = 1'b0;
      a = 8'h00; b = 8'h00;
      for (int i = 0; i < 3; i++) begin outs[i] = 0; lat[i] = 0; busy[i] = 1'b0; lchk[i] = 1'b0; end
      tick(2);
      chk("rst_in_ready", if4.in_ready, 1);
      chk("rst_out_valid", if4.out_valid, 0);
      chk_all("rst_outputs", 10'h000);
      rst_n = 1'b1;
      tick();

      // 0x7F + 0x01: step through handshake timing on the DIGIT=4 instance
      op_sub = 1'b0; a = 8'h7F; b = 8'h01; ci = 1'b0; out_ready = 1'b1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_ops++;
      chk("t1_in_ready_run", if4.in_ready, 0);
      chk("t1_out_valid_e0", if4.out_valid, 0);
      tick();
      chk("t1_out_valid_e1", if4.out_valid, 0);
      tick();
      chk("t1_out_valid_e2", if4.out_valid, 1);
      chk("t1_in_ready_done", if4.in_ready, 0);
      chk("t1_result", obs[0], 10'h280);
      tick();
      chk("t1_in_ready_back", if4.in_ready, 1);
      chk("t1_out_valid_drop", if4.out_valid, 0);
      wait_idle();
      chk_all("t1_hold", 10'h280);

      issue(1'b1, 8'h05, 8'h07, 1'b0); chk_all("sub_05_07", 10'h1FE);
      issue(1'b1, 8'h80, 8'h01, 1'b0); chk_all("sub_80_01", 10'h27F);
      issue(1'b0, 8'hFF, 8'h00, 1'b1); chk_all("add_ff_00_c", 10'h100);
      issue(1'b1, 8'h00, 8'h00, 1'b1); chk_all("sub_00_00_b", 10'h1FF);

      // Backpressure with new operands waiting on in_valid
      out_ready = 1'b0;
      op_sub = 1'b0; a = 8'h12; b = 8'h34; ci = 1'b0;
      in_valid = 1'b1;
      tick();
      op_sub = 1'b1; a = 8'h50; b = 8'h21; ci = 1'b1;
      k = 0;
      while (!if4.out_valid && k < 20) begin tick(); k++; end
      chk("bp_done", if4.out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_result_stable", obs[0], 10'h046);
         chk("bp_in_ready_low", if4.in_ready, 0);
         chk("bp_out_valid_high", if4.out_valid, 1);
         tick();
      end
      k = 0;
      while (!(ov[0] && ov[1] && ov[2]) && k < 20) begin tick(); k++; end
      chk("bp_all_done", {31'd0, ov[0] && ov[1] && ov[2]}, 1);
      chk_all("bp_x", 10'h046);
      out_ready = 1'b1;
      tick();
      chk("bp_idle_cycle", if4.in_ready, 1);
      tick();
      chk("bp_captured", if4.in_ready, 0);
      in_valid = 1'b0;
      n_ops += 2;
      wait_idle();
      chk_all("bp_y", 10'h02E);

      // Asynchronous reset during the first RUN cycle
      op_sub = 1'b0; a = 8'hFF; b = 8'hFF; ci = 1'b1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_in_ready", if4.in_ready, 1);
      chk("arst_out_valid", if4.out_valid, 0);
      chk_all("arst_outputs", 10'h000);
      tick();
      rst_n = 1'b1;
      tick();
      issue(1'b0, 8'h10, 8'h20, 1'b0); chk_all("post_rst_add", 10'h030);

      for (int i = 0; i < 1000; i++)
         issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

      tick(2);
      for (int i = 0; i < 3; i++) chk($sformatf("result_count_i%0d", i), outs[i], n_ops);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
